delay_stats: RTL

//  Consumes per-frame delay results from the frame timer (20-bit tx_clk cycle

---
 rtl/delay_stats.sv | 118 +++++++++++
 1 files changed

// File: rtl/delay_stats.sv
// Windowed delay statistics: collects 2^WIN_LOG2 accepted delay samples and
// publishes min/max/avg/lost through a valid/ack result interface.
module delay_stats #(
  parameter int DELAY_W  = 20,
  parameter int WIN_LOG2 = 4,
  parameter int LOST_W   = 16
) (
  input  logic               tx_clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               clear,
  input  logic               meas_valid,
  input  logic [DELAY_W-1:0] meas_delay,
  input  logic               meas_lost,
  input  logic               result_ack,
  output logic               result_valid,
  output logic [DELAY_W-1:0] res_min,
  output logic [DELAY_W-1:0] res_max,
  output logic [DELAY_W-1:0] res_avg,
  output logic [LOST_W-1:0]  res_lost,
  output logic               overrun
);

  localparam int SUM_W = DELAY_W + WIN_LOG2;

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t              state, state_nxt;
  logic [DELAY_W-1:0]  min_q, max_q, min_new, max_new;
  logic [SUM_W-1:0]    sum_q, sum_new, delay_ext;
  logic [WIN_LOG2:0]   cnt_q, cnt_new;
  logic [LOST_W-1:0]   lost_q, lost_new;
  logic                accept, lost_inc, complete;

  always_comb begin
    accept    = enable && meas_valid && !meas_lost && !clear;
    lost_inc  = enable && meas_lost && !clear;
    delay_ext = {{WIN_LOG2{1'b0}}, meas_delay};
    min_new   = meas_delay;
    max_new   = meas_delay;
    sum_new   = delay_ext;
    cnt_new   = {{WIN_LOG2{1'b0}}, 1'b1};
    if (state == ACCUM) begin
      min_new = (meas_delay < min_q) ? meas_delay : min_q;
      max_new = (meas_delay > max_q) ? meas_delay : max_q;
      sum_new = sum_q + delay_ext;
      cnt_new = cnt_q + 1'b1;
    end
    lost_new = (lost_inc && lost_q != '1) ? lost_q + 1'b1 : lost_q;
    // cnt never exceeds 2^WIN_LOG2, so its top bit marks the final sample
    complete = accept && cnt_new[WIN_LOG2];

    state_nxt = state;
    if (clear || !enable || complete)
      state_nxt = IDLE;
    else if (accept)
      state_nxt = ACCUM;
  end

  always_ff @(posedge tx_clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge tx_clk or posedge reset) begin
    if (reset) begin
      min_q        <= '0;
      max_q        <= '0;
      sum_q        <= '0;
      cnt_q        <= '0;
      lost_q       <= '0;
      res_min      <= '0;
      res_max      <= '0;
      res_avg      <= '0;
      res_lost     <= '0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (clear || !enable || complete) begin
        min_q  <= '0;
        max_q  <= '0;
        sum_q  <= '0;
        cnt_q  <= '0;
        lost_q <= '0;
      end else begin
        if (accept) begin
          min_q <= min_new;
          max_q <= max_new;
          sum_q <= sum_new;
          cnt_q <= cnt_new;
        end
        lost_q <= lost_new;
      end

      if (complete) begin
        res_min  <= min_new;
        res_max  <= max_new;
        res_avg  <= sum_new[SUM_W-1:WIN_LOG2];
        res_lost <= lost_new;
      end

      // a completion outranks a same-cycle ack
      if (clear) begin
        result_valid <= 1'b0;
        overrun      <= 1'b0;
      end else if (complete) begin
        result_valid <= 1'b1;
        if (result_valid && !result_ack)
          overrun <= 1'b1;
      end else if (result_ack) begin
        result_valid <= 1'b0;
      end
    end
  end

endmodule
